stage_3: RTL and testbench
==========================

# stage_3

Execute stage of the five-stage RISC-V pipeline, consuming the decoded operation bundle produced by the decode stage. Owns the ID/EX and EX/MEM pipeline registers, evaluates the ALU operation, and feeds back `id_ex_rd_num`/`ex_mem_rd_num` for decode-side hazard detection. With the multiply option compiled in, runs an iterative 32-cycle multiplier and back-pressures decode via `stall`.

## Interface
Parameters: none (widths fixed at RV32).
- `i_clk` in 1: pipeline clock, all state on rising edge
- `i_rst` in 1: reset, asynchronous, active-high
- `i_pc` in 32: PC of decoded instruction
- `i_rd_num` in 5: destination register; 0 = no writeback / bubble
- `i_alu_op_1` in 32: resolved first operand value
- `i_alu_op_2` in 32: resolved second operand value
- `i_alu_op` in 4: ALU operation code
- `i_mem_op` in 3: memory operation code, passed through
- `i_alu_mem_op` in 1: `ALU_OP` / `MEM_OP` select, passed through
- `i_st_data` in 32: rs_2 value for stores, passed through
- `stall` out 1: hold decode and fetch this cycle
- `id_ex_rd_num` out 5: rd held in ID/EX register
- `ex_mem_rd_num` out 5: rd held in EX/MEM register
- `pc` out 32: EX/MEM PC
- `alu_result` out 32: EX/MEM result (address for memory ops)
- `st_data` out 32: EX/MEM store data
- `mem_op` out 3: EX/MEM memory op
- `alu_mem_op` out 1: EX/MEM ALU/memory select

## Operation
- ID/EX register loads all `i_*` inputs every rising edge while `stall`=0; holds while `stall`=1.
- ALU evaluates ID/EX contents combinationally; 32-bit results, wrap mod 2^32.
- ADD/SUB; AND/OR/XOR; SLT signed, SLTU unsigned → 0/1; SLL/SRL/SRA shift by op_2[4:0], SRA sign-fills.
- Undefined `alu_op` → result 0.
- EX/MEM register loads ALU result plus pass-through fields when `stall`=0; while `stall`=1, loads a bubble: rd_num 0, result 0, mem_op 0, alu_mem_op `ALU_OP`, pc 0, st_data 0.
- Bubbles from decode (rd_num 0, operands 0) flow through unchanged; no valid bit.
- Multiplier FSM (macro only): IDLE, RUN, DONE.
  - IDLE, ID/EX holds MUL/MULH/MULHSU/MULHU → `stall`=1; on the edge, latch operand magnitudes and sign flag; counter ← 0; → RUN.
  - RUN: one shift-add per cycle into 64-bit accumulator; `stall`=1; counter 31 → DONE.
  - DONE: `stall`=0; negate product if sign flag set; MUL → low 32, others → high 32; EX/MEM loads it with ID/EX fields; → IDLE.
  - Signedness: MULH both signed; MULHSU op_1 signed, op_2 unsigned; MULHU both unsigned.
- Two consecutive multiplies: second enters ID/EX at DONE edge, restarts from IDLE next cycle.
- Asynchronous reset: all registers 0, FSM IDLE, counter 0, mid-multiply operation discarded.

## Timing
- Reset values: every output 0; `stall` 0.
- Non-multiply latency: inputs at cycle N → ID/EX at edge N → EX/MEM outputs after edge N+1.
- Multiply: in ID/EX from edge N; `stall` high cycles N+1..N+33 (33 cycles); DONE cycle N+34; result on outputs after edge N+34.
- `stall` is combinational from FSM state and ID/EX op; no dependence on inputs in the same cycle.

## Configuration
- `STAGE_3_MUL_EN` defined: multiplier FSM and codes `ALU_MUL`..`ALU_MULHU` active.
- Undefined: no FSM; `stall` tied 0; multiply codes fall into undefined → result 0, single-cycle.

## Structure
- `constants.vh` holds `ALU_ADD`=0, `ALU_SUB`=1, `ALU_SLT`=2, `ALU_SLTU`=3, `ALU_AND`=4, `ALU_OR`=5, `ALU_XOR`=6, `ALU_SLL`=7, `ALU_SRL`=8, `ALU_SRA`=9, `ALU_MUL`=10, `ALU_MULH`=11, `ALU_MULHSU`=12, `ALU_MULHU`=13, `ALU_OP`/`MEM_OP`, memory op codes, FSM state encodings.
- One sub-module `mul_unit`: iterative multiplier and FSM, start/done handshake; instantiated only under `STAGE_3_MUL_EN`.

## Test plan
- Reset mid-stream → all outputs 0, `stall` 0.
- SUB: op_1=5, op_2=7, rd=3 at cycle 0 → cycle 2: `alu_result`=0xFFFFFFFE, `ex_mem_rd_num`=3; `id_ex_rd_num`=3 during cycle 1.
- SRA: 0x80000000 by op_2=0x24 → 0xF8000000; SLT/SLTU with 0xFFFFFFFF vs 1 → 1 and 0.
- MULH: 0xFFFFFFFE × 3 with macro → `stall` high exactly 33 cycles, EX/MEM rd_num 0 meanwhile, then result 0xFFFFFFFF; MUL low = 0xFFFFFFFA.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; back-to-back MULHSU follows with second 33-cycle stall.
- `i_rst` pulsed at RUN counter 10 → IDLE, `stall` 0, no result emitted; next ADD 1+1 → 2 after two edges.

Source files
------------

// File: rtl/stage_3_pkg.sv
// Shared constants and types for the RV32 execute stage: ALU codes, memory op codes,
// the ALU/memory select values and the multiplier FSM encoding.
package stage_3_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLT    = 4'd2;
    localparam logic [3:0] ALU_SLTU   = 4'd3;
    localparam logic [3:0] ALU_AND    = 4'd4;
    localparam logic [3:0] ALU_OR     = 4'd5;
    localparam logic [3:0] ALU_XOR    = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRL    = 4'd8;
    localparam logic [3:0] ALU_SRA    = 4'd9;
    localparam logic [3:0] ALU_MUL    = 4'd10;
    localparam logic [3:0] ALU_MULH   = 4'd11;
    localparam logic [3:0] ALU_MULHSU = 4'd12;
    localparam logic [3:0] ALU_MULHU  = 4'd13;

    localparam logic ALU_OP = 1'b0;
    localparam logic MEM_OP = 1'b1;

    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LH  = 3'd1;
    localparam logic [2:0] MEM_LW  = 3'd2;
    localparam logic [2:0] MEM_LBU = 3'd3;
    localparam logic [2:0] MEM_LHU = 3'd4;
    localparam logic [2:0] MEM_SB  = 3'd5;
    localparam logic [2:0] MEM_SH  = 3'd6;
    localparam logic [2:0] MEM_SW  = 3'd7;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd_num;
        logic [31:0] op_1;
        logic [31:0] op_2;
        logic [3:0]  alu_op;
        logic [2:0]  mem_op;
        logic        alu_mem_op;
        logic [31:0] st_data;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd_num;
        logic [31:0] result;
        logic [31:0] st_data;
        logic [2:0]  mem_op;
        logic        alu_mem_op;
    } ex_mem_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op >= ALU_MUL) && (op <= ALU_MULHU);
    endfunction

endpackage

// File: rtl/stage_3_if.sv
// Decode-to-execute bundle plus the execute stage's forwarded state and EX/MEM outputs.
interface stage_3_if;
    logic [31:0] i_pc;
    logic [4:0]  i_rd_num;
    logic [31:0] i_alu_op_1;
    logic [31:0] i_alu_op_2;
    logic [3:0]  i_alu_op;
    logic [2:0]  i_mem_op;
    logic        i_alu_mem_op;
    logic [31:0] i_st_data;
    logic        stall;
    logic [4:0]  id_ex_rd_num;
    logic [4:0]  ex_mem_rd_num;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] st_data;
    logic [2:0]  mem_op;
    logic        alu_mem_op;

    modport master (
        output i_pc, i_rd_num, i_alu_op_1, i_alu_op_2, i_alu_op, i_mem_op, i_alu_mem_op, i_st_data,
        input  stall, id_ex_rd_num, ex_mem_rd_num, pc, alu_result, st_data, mem_op, alu_mem_op
    );

    modport slave (
        input  i_pc, i_rd_num, i_alu_op_1, i_alu_op_2, i_alu_op, i_mem_op, i_alu_mem_op, i_st_data,
        output stall, id_ex_rd_num, ex_mem_rd_num, pc, alu_result, st_data, mem_op, alu_mem_op
    );
endinterface

// File: rtl/stage_3_mul_unit.sv
// Iterative 32x32 shift-add multiplier with IDLE/RUN/DONE FSM; busy stalls decode,
// done marks the single cycle the product is valid. Used only with STAGE_3_MUL_EN.
module mul_unit
    import stage_3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] op_1,
    input  logic [31:0] op_2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    mul_state_e  state, state_next;
    logic [31:0] mcand, mplier;
    logic [63:0] acc, product;
    logic [4:0]  count;
    logic        neg;

    // Operand sign handling: work on magnitudes, fix up the sign once at the end.
    logic        sign_1, sign_2;
    logic [31:0] mag_1, mag_2;
    assign sign_1 = ((op == ALU_MULH) || (op == ALU_MULHSU)) && op_1[31];
    assign sign_2 = (op == ALU_MULH) && op_2[31];
    assign mag_1  = sign_1 ? -op_1 : op_1;
    assign mag_2  = sign_2 ? -op_2 : op_2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MUL_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MUL_IDLE: if (start) state_next = MUL_RUN;
            MUL_RUN:  if (count == 5'd31) state_next = MUL_DONE;
            MUL_DONE: state_next = MUL_IDLE;
            default:  state_next = MUL_IDLE;
        endcase
    end

    always_comb begin
        busy    = ((state == MUL_IDLE) && start) || (state == MUL_RUN);
        done    = (state == MUL_DONE);
        product = neg ? -acc : acc;
        result  = (op == ALU_MUL) ? product[31:0] : product[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: if (start) begin
                    mcand  <= mag_1;
                    mplier <= mag_2;
                    neg    <= sign_1 ^ sign_2;
                    acc    <= '0;
                    count  <= '0;
                end
                MUL_RUN: begin
                    if (mplier[count]) acc <= acc + ({32'd0, mcand} << count);
                    count <= count + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stage_3.sv
// RV32 execute stage: ID/EX and EX/MEM registers around the ALU. Defining STAGE_3_MUL_EN
// adds the iterative multiplier (mul_unit) and lets it stall decode.
module stage_3
    import stage_3_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    stage_3_if.slave bus
);

    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    logic        stall;
    logic [31:0] alu_y;

`ifdef STAGE_3_MUL_EN
    logic        mul_start, mul_done;
    logic [31:0] mul_y;
    assign mul_start = is_mul_op(id_ex.alu_op);

    mul_unit u_mul (
        .clk    (i_clk),
        .rst    (i_rst),
        .start  (mul_start),
        .op     (id_ex.alu_op),
        .op_1   (id_ex.op_1),
        .op_2   (id_ex.op_2),
        .busy   (stall),
        .done   (mul_done),
        .result (mul_y)
    );
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        // NOTE: alu_y gets a default before the case so every path assigns it and no latch is inferred.
        alu_y = '0;
        case (id_ex.alu_op)
            ALU_ADD:  alu_y = id_ex.op_1 + id_ex.op_2;
            ALU_SUB:  alu_y = id_ex.op_1 - id_ex.op_2;
            ALU_SLT:  alu_y = {31'd0, $signed(id_ex.op_1) < $signed(id_ex.op_2)};
            ALU_SLTU: alu_y = {31'd0, id_ex.op_1 < id_ex.op_2};
            ALU_AND:  alu_y = id_ex.op_1 & id_ex.op_2;
            ALU_OR:   alu_y = id_ex.op_1 | id_ex.op_2;
            ALU_XOR:  alu_y = id_ex.op_1 ^ id_ex.op_2;
            ALU_SLL:  alu_y = id_ex.op_1 << id_ex.op_2[4:0];
            ALU_SRL:  alu_y = id_ex.op_1 >> id_ex.op_2[4:0];
            ALU_SRA:  alu_y = $signed(id_ex.op_1) >>> id_ex.op_2[4:0];
`ifdef STAGE_3_MUL_EN
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_y = mul_done ? mul_y : 32'd0;
`endif
            default:  alu_y = '0;
        endcase
    end

    // NOTE: non-blocking assignments on all registered state so each flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            id_ex <= '0;
        end else if (!stall) begin
            id_ex.pc         <= bus.i_pc;
            id_ex.rd_num     <= bus.i_rd_num;
            id_ex.op_1       <= bus.i_alu_op_1;
            id_ex.op_2       <= bus.i_alu_op_2;
            id_ex.alu_op     <= bus.i_alu_op;
            id_ex.mem_op     <= bus.i_mem_op;
            id_ex.alu_mem_op <= bus.i_alu_mem_op;
            id_ex.st_data    <= bus.i_st_data;
        end
    end

    // While stalled, a zero bubble (rd 0, ALU_OP) goes down the pipe instead of the held op.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_mem <= '0;
        end else if (stall) begin
            ex_mem            <= '0;
            ex_mem.alu_mem_op <= ALU_OP;
        end else begin
            ex_mem.pc         <= id_ex.pc;
            ex_mem.rd_num     <= id_ex.rd_num;
            ex_mem.result     <= alu_y;
            ex_mem.st_data    <= id_ex.st_data;
            ex_mem.mem_op     <= id_ex.mem_op;
            ex_mem.alu_mem_op <= id_ex.alu_mem_op;
        end
    end

    assign bus.stall         = stall;
    assign bus.id_ex_rd_num  = id_ex.rd_num;
    assign bus.ex_mem_rd_num = ex_mem.rd_num;
    assign bus.pc            = ex_mem.pc;
    assign bus.alu_result    = ex_mem.result;
    assign bus.st_data       = ex_mem.st_data;
    assign bus.mem_op        = ex_mem.mem_op;
    assign bus.alu_mem_op    = ex_mem.alu_mem_op;

endmodule

// File: tb/tb_stage_3.sv
// Scoreboard bench for stage_3: a driver pushes expected EX/MEM contents and stall lengths,
// a negedge monitor pops and compares. Multiply expectations follow STAGE_3_MUL_EN.
module tb_stage_3;
    import stage_3_pkg::*;

`ifdef STAGE_3_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage_3_if bus ();
    stage_3 dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] st_data;
        logic [4:0]  rd;
        logic [2:0]  mem_op;
        logic        alu_mem_op;
    } exp_t;

    exp_t exp_q[$];
    int   stall_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ALU computed straight from the instruction definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef STAGE_3_MUL_EN
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
`endif
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
`ifdef STAGE_3_MUL_EN
            ALU_MUL:    begin p = ua * ub;              return p[31:0];  end
            ALU_MULH:   begin p = sa * sb;              return p[63:32]; end
            ALU_MULHSU: begin p = sa * longint'(ub);    return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub;              return p[63:32]; end
`endif
            default:  return 32'd0;
        endcase
    endfunction

    // Entered just after a negedge; presents the op, waits for an accepting edge, exits after the next negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] sd, input logic [4:0] rd,
                         input logic [2:0] mo, input logic amo);
        logic s;
        bit   accepted;
        exp_t e;
        accepted         = 1'b0;
        bus.i_alu_op     = op;
        bus.i_alu_op_1   = a;
        bus.i_alu_op_2   = b;
        bus.i_pc         = pc;
        bus.i_st_data    = sd;
        bus.i_rd_num     = rd;
        bus.i_mem_op     = mo;
        bus.i_alu_mem_op = amo;
        for (int k = 0; k < 100 && !accepted; k++) begin
            s = bus.stall;
            @(posedge clk);
            if (!s) begin
                accepted = 1'b1;
                if (rd != 5'd0) begin
                    e.pc = pc; e.result = ref_alu(op, a, b); e.st_data = sd;
                    e.rd = rd; e.mem_op = mo; e.alu_mem_op = amo;
                    exp_q.push_back(e);
                end
                if (MUL_ON && op >= ALU_MUL && op <= ALU_MULHU) stall_q.push_back(33);
            end
            @(negedge clk);
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got stall held expected accept within 100 cycles");
        end
    endtask

    task automatic bubble();
        issue(ALU_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, ALU_OP);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run = 0;
        end else if (mon_en) begin
            if (bus.stall) begin
                run++;
            end else if (run > 0) begin
                if (stall_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stall_unexpected: got stall run %0d expected none", run);
                end else begin
                    check("stall_len", run, stall_q.pop_front());
                end
                run = 0;
            end
            if (bus.ex_mem_rd_num != 5'd0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL result_unexpected: got rd %0d expected none", bus.ex_mem_rd_num);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_num", {27'd0, bus.ex_mem_rd_num}, {27'd0, e.rd});
                    check("result", bus.alu_result, e.result);
                    check("pc", bus.pc, e.pc);
                    check("st_data", bus.st_data, e.st_data);
                    check("mem_op", {29'd0, bus.mem_op}, {29'd0, e.mem_op});
                    check("alu_mem_op", {31'd0, bus.alu_mem_op}, {31'd0, e.alu_mem_op});
                end
            end else begin
                check("bubble_zero", bus.alu_result | bus.pc | bus.st_data |
                      {28'd0, bus.mem_op, bus.alu_mem_op}, 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
        check({tag, "_id_ex_rd"}, {27'd0, bus.id_ex_rd_num}, 32'd0);
        check({tag, "_ex_mem_rd"}, {27'd0, bus.ex_mem_rd_num}, 32'd0);
        check({tag, "_pc"}, bus.pc, 32'd0);
        check({tag, "_result"}, bus.alu_result, 32'd0);
        check({tag, "_st_data"}, bus.st_data, 32'd0);
        check({tag, "_mem_op"}, {28'd0, bus.mem_op, bus.alu_mem_op}, 32'd0);
    endtask

    initial begin
        bus.i_pc = '0; bus.i_rd_num = '0; bus.i_alu_op_1 = '0; bus.i_alu_op_2 = '0;
        bus.i_alu_op = '0; bus.i_mem_op = '0; bus.i_alu_mem_op = 1'b0; bus.i_st_data = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        issue(ALU_SUB, 32'd5, 32'd7, 32'h100, 32'd0, 5'd3, MEM_LB, ALU_OP);
        check("sub_id_ex_rd", {27'd0, bus.id_ex_rd_num}, 32'd3);
        bubble();
        check("sub_result", bus.alu_result, 32'hFFFFFFFE);
        check("sub_ex_mem_rd", {27'd0, bus.ex_mem_rd_num}, 32'd3);

        issue(ALU_SRA, 32'h80000000, 32'h24, 32'h104, 32'd0, 5'd4, MEM_LB, ALU_OP);
        issue(ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'h108, 32'd0, 5'd5, MEM_LB, ALU_OP);
        check("sra_result", bus.alu_result, 32'hF8000000);
        issue(ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'h10C, 32'd0, 5'd6, MEM_LB, ALU_OP);
        check("slt_result", bus.alu_result, 32'd1);
        bubble();
        check("sltu_result", bus.alu_result, 32'd0);

        issue(ALU_MULH, 32'hFFFFFFFE, 32'd3, 32'h110, 32'd0, 5'd7, MEM_LB, ALU_OP);
        issue(ALU_MUL, 32'hFFFFFFFE, 32'd3, 32'h114, 32'd0, 5'd8, MEM_LB, ALU_OP);
        check("mulh_result", bus.alu_result, MUL_ON ? 32'hFFFFFFFF : 32'd0);
        issue(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h118, 32'd0, 5'd9, MEM_LB, ALU_OP);
        check("mul_result", bus.alu_result, MUL_ON ? 32'hFFFFFFFA : 32'd0);
        issue(ALU_MULHSU, 32'hFFFFFFFF, 32'd2, 32'h11C, 32'd0, 5'd10, MEM_LB, ALU_OP);
        check("mulhu_result", bus.alu_result, MUL_ON ? 32'hFFFFFFFE : 32'd0);
        bubble();
        check("mulhsu_result", bus.alu_result, MUL_ON ? 32'hFFFFFFFF : 32'd0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7) == 0) begin
                bubble();
            end else begin
                issue(4'($urandom_range(15)), $urandom, ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom,
                      $urandom, $urandom, 5'($urandom_range(31, 1)), 3'($urandom_range(7)), 1'($urandom_range(1)));
            end
        end
        repeat (3) bubble();

        // Reset in the middle of a multiply: nothing may come out of it afterwards.
        bus.i_alu_op = ALU_MULHU; bus.i_alu_op_1 = 32'd7; bus.i_alu_op_2 = 32'd9;
        bus.i_rd_num = 5'd0; bus.i_pc = '0; bus.i_st_data = '0; bus.i_mem_op = '0; bus.i_alu_mem_op = ALU_OP;
        @(posedge clk);
        @(negedge clk);
        bus.i_alu_op = ALU_ADD; bus.i_alu_op_1 = '0; bus.i_alu_op_2 = '0;
        repeat (11) @(negedge clk);
        check("mid_mul_stall", {31'd0, bus.stall}, {31'd0, MUL_ON});
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        stall_q.delete();
        check("post_reset_stall", {31'd0, bus.stall}, 32'd0);
        issue(ALU_ADD, 32'd1, 32'd1, 32'h200, 32'd0, 5'd11, MEM_LB, ALU_OP);
        bubble();
        check("add_after_reset", bus.alu_result, 32'd2);
        check("add_after_reset_rd", {27'd0, bus.ex_mem_rd_num}, 32'd11);
        repeat (3) bubble();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("stall_q_drained", 32'(stall_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
